// File: rtl/brain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : brain_pkg
//  Description : Shared types and sizing constants for the BRAIN array
//                sequencer (state encoding, chain geometry, counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package brain_pkg;

    localparam int N_NEURONS       = 25;
    localparam int BITS_PER_NEURON = 17;
    localparam int TOTAL_BITS      = N_NEURONS * BITS_PER_NEURON;
    localparam int BIT_CNT_W       = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_SHIFT = 3'd2,
        ST_RUN   = 3'd3,
        ST_CLEAR = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

endpackage : brain_pkg
`default_nettype wire

// File: rtl/decay_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : decay_prescaler
//  Description : 8-bit free-running prescaler for the decay clock bus. Line i
//                pulses for one cycle whenever the low i+1 count bits are all
//                ones. Count and bus are zero whenever advance is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module decay_prescaler (
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    output logic [7:0] dbus
);

    logic [7:0] r_p;
    logic [7:0] r_dbus;
    logic [7:0] w_p_inc;
    logic [7:0] w_dbus_next;

    assign w_p_inc = r_p + 8'd1;

    // Decode is taken from the incremented count so the bus register lines up
    // with the count register it describes.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_decode
            assign w_dbus_next[gi] = &w_p_inc[gi:0];
        end
    endgenerate

    // Count while advancing; otherwise hold count and bus at zero.
    always_ff @(posedge clk) begin
        if (rst || !advance) begin
            r_p    <= 8'd0;
            r_dbus <= 8'd0;
        end else begin
            r_p    <= w_p_inc;
            r_dbus <= w_dbus_next;
        end
    end

    assign dbus = r_dbus;

endmodule : decay_prescaler
`default_nettype wire

// File: rtl/brain_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : brain_sequencer
//  Description : Streams a byte-wide configuration bitstream into the BRAIN
//                serial chain with no bubbles, then sequences the array's
//                reset / run phases and drives the decay clock bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module brain_sequencer #(
    parameter int N_NEURONS       = brain_pkg::N_NEURONS,
    parameter int BITS_PER_NEURON = brain_pkg::BITS_PER_NEURON,
    parameter int CLEAR_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       nn_reset,
    input  logic       cfg_start,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       nn_clear,
    output logic       conf_en,
    output logic       bs_in,
    output logic       brain_reset,
    output logic [7:0] dBus,
    output logic       busy,
    output logic       cfg_done,
    output logic       cfg_err
);

    import brain_pkg::*;

    localparam int                     c_total_bits = N_NEURONS * BITS_PER_NEURON;
    localparam logic [BIT_CNT_W-1:0]   c_last_bit   = BIT_CNT_W'(c_total_bits - 1);
    localparam logic [BIT_CNT_W-1:0]   c_bit_one    = BIT_CNT_W'(1);
    localparam int                     c_clr_w      = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [c_clr_w-1:0]     c_clr_load   = c_clr_w'(CLEAR_CYCLES - 1);
    localparam logic [c_clr_w-1:0]     c_clr_one    = c_clr_w'(1);

    state_t                 r_state;
    state_t                 w_next_state;

    // Byte skid: r_shift holds the bits still to follow the one on bs_in,
    // r_shift_cnt says how many of them are valid; r_hold is the spare byte.
    logic [6:0]             r_shift;
    logic [2:0]             r_shift_cnt;
    logic [7:0]             r_hold;
    logic                   r_hold_full;
    logic                   w_hold_full_next;

    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [c_clr_w-1:0]     r_clr_cnt;

    logic                   r_byte_ready;
    logic                   r_conf_en;
    logic                   r_bs_in;
    logic                   r_brain_reset;
    logic                   r_busy;
    logic                   r_cfg_done;
    logic                   r_cfg_err;

    logic                   w_accept;
    logic                   w_last_bit;
    logic                   w_shift_empty;
    logic                   w_next_bs;
    logic                   w_run_advance;

    assign w_accept      = r_byte_ready & byte_valid;
    assign w_last_bit    = (r_bit_cnt == c_last_bit);
    assign w_shift_empty = (r_shift_cnt == 3'd0);

    // Next-state decision; cfg_start outranks nn_clear, underrun is fatal.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cfg_start) w_next_state = ST_PRIME;
            end
            ST_PRIME: begin
                if (w_accept) w_next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_last_bit)                         w_next_state = ST_RUN;
                else if (w_shift_empty && !r_hold_full) w_next_state = ST_ERR;
            end
            ST_RUN: begin
                if (cfg_start)     w_next_state = ST_PRIME;
                else if (nn_clear) w_next_state = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (cfg_start)                             w_next_state = ST_PRIME;
                else if (!nn_clear && r_clr_cnt == '0)     w_next_state = ST_RUN;
            end
            ST_ERR: begin
                if (cfg_start) w_next_state = ST_PRIME;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Holding-register occupancy and the next serial bit to present.
    always_comb begin
        w_hold_full_next = 1'b0;
        w_next_bs        = 1'b0;
        if (r_state == ST_PRIME && w_accept) begin
            w_next_bs = byte_data[7];
        end else if (r_state == ST_SHIFT && w_next_state == ST_SHIFT) begin
            w_hold_full_next = r_hold_full;
            if (w_shift_empty) begin
                w_hold_full_next = 1'b0;
                w_next_bs        = r_hold[7];
            end else begin
                w_next_bs = r_shift[6];
            end
            if (w_accept) w_hold_full_next = 1'b1;
        end
    end

    // State, skid registers, bit counter and clear counter.
    always_ff @(posedge clk) begin
        if (nn_reset) begin
            r_state     <= ST_IDLE;
            r_shift     <= 7'd0;
            r_shift_cnt <= 3'd0;
            r_hold      <= 8'd0;
            r_hold_full <= 1'b0;
            r_bit_cnt   <= '0;
            r_clr_cnt   <= '0;
        end else begin
            r_state     <= w_next_state;
            r_hold_full <= w_hold_full_next;

            if (r_state == ST_SHIFT && w_accept) r_hold <= byte_data;

            if (w_next_state == ST_PRIME && r_state != ST_PRIME) begin
                r_bit_cnt <= '0;
            end else if (r_state == ST_SHIFT && w_next_state == ST_SHIFT) begin
                r_bit_cnt <= r_bit_cnt + c_bit_one;
            end

            if (r_state == ST_PRIME && w_accept) begin
                r_shift     <= byte_data[6:0];
                r_shift_cnt <= 3'd7;
            end else if (r_state == ST_SHIFT && w_next_state == ST_SHIFT) begin
                if (w_shift_empty) begin
                    r_shift     <= r_hold[6:0];
                    r_shift_cnt <= 3'd7;
                end else begin
                    r_shift     <= {r_shift[5:0], 1'b0};
                    r_shift_cnt <= r_shift_cnt - 3'd1;
                end
            end

            if (w_next_state == ST_CLEAR) begin
                if (r_state != ST_CLEAR || nn_clear) r_clr_cnt <= c_clr_load;
                else                                 r_clr_cnt <= r_clr_cnt - c_clr_one;
            end
        end
    end

    // All array-facing and status outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (nn_reset) begin
            r_byte_ready  <= 1'b0;
            r_conf_en     <= 1'b0;
            r_bs_in       <= 1'b0;
            r_brain_reset <= 1'b1;
            r_busy        <= 1'b0;
            r_cfg_done    <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_byte_ready  <= (w_next_state == ST_PRIME) ||
                             (w_next_state == ST_SHIFT && !w_hold_full_next);
            r_conf_en     <= (w_next_state == ST_SHIFT);
            r_bs_in       <= w_next_bs;
            r_brain_reset <= (w_next_state == ST_IDLE)  || (w_next_state == ST_PRIME) ||
                             (w_next_state == ST_CLEAR) || (w_next_state == ST_ERR);
            r_busy        <= (w_next_state == ST_PRIME) || (w_next_state == ST_SHIFT);
            r_cfg_done    <= (w_next_state == ST_RUN)   || (w_next_state == ST_CLEAR);
            r_cfg_err     <= (w_next_state == ST_ERR);
        end
    end

    // The prescaler only advances across consecutive RUN cycles, so it restarts
    // from zero on every entry to RUN.
    assign w_run_advance = (r_state == ST_RUN) && (w_next_state == ST_RUN);

    decay_prescaler u_prescaler (
        .clk     (clk),
        .rst     (nn_reset),
        .advance (w_run_advance),
        .dbus    (dBus)
    );

    assign byte_ready  = r_byte_ready;
    assign conf_en     = r_conf_en;
    assign bs_in       = r_bs_in;
    assign brain_reset = r_brain_reset;
    assign busy        = r_busy;
    assign cfg_done    = r_cfg_done;
    assign cfg_err     = r_cfg_err;

endmodule : brain_sequencer
`default_nettype wire

// File: tb/tb_brain_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_brain_sequencer
//  Description : Randomized self-checking bench for brain_sequencer with a
//                behavioural model of load / run / clear / error behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_brain_sequencer;

    localparam int NB    = 54;
    localparam int TOTAL = 425;
    localparam int CLRC  = 2;

    localparam int M_IDLE = 0, M_PRIME = 1, M_SHIFT = 2, M_RUN = 3, M_CLEAR = 4, M_ERR = 5;

    logic       clk = 1'b0;
    logic       nn_reset = 1'b1;
    logic       cfg_start = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       nn_clear = 1'b0;
    logic       byte_ready, conf_en, bs_in, brain_reset, busy, cfg_done, cfg_err;
    logic [7:0] dBus;

    always #5 clk = ~clk;

    brain_sequencer #(.N_NEURONS(25), .BITS_PER_NEURON(17), .CLEAR_CYCLES(CLRC)) dut (
        .clk(clk), .nn_reset(nn_reset), .cfg_start(cfg_start), .byte_data(byte_data),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .nn_clear(nn_clear),
        .conf_en(conf_en), .bs_in(bs_in), .brain_reset(brain_reset), .dBus(dBus),
        .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    int checks = 0;
    int errors = 0;
    int nprint = 0;
    logic chk_en = 1'b0;

    // ---------------- behavioural model ----------------
    int         m_mode = M_IDLE;
    logic       m_cur  = 1'b0;
    int         m_idx  = 0;
    int         m_p    = 0;
    int         m_clr  = 0;
    logic       m_rest[$];
    logic [7:0] m_hold[$];

    function automatic logic model_ready();
        return (m_mode == M_PRIME) || (m_mode == M_SHIFT && m_hold.size() == 0);
    endfunction

    function automatic logic [14:0] model_outputs();
        logic [7:0] d;
        int mask;
        d = 8'h00;
        if (m_mode == M_RUN)
            for (int i = 0; i < 8; i++) begin
                mask = (2 << i) - 1;
                d[i] = ((m_p & mask) == mask);
            end
        return {m_mode == M_SHIFT, (m_mode == M_SHIFT) ? m_cur : 1'b0,
                m_mode == M_IDLE || m_mode == M_PRIME || m_mode == M_CLEAR || m_mode == M_ERR,
                d, model_ready(), m_mode == M_PRIME || m_mode == M_SHIFT,
                m_mode == M_RUN || m_mode == M_CLEAR, m_mode == M_ERR};
    endfunction

    function automatic void model_prime();
        m_mode = M_PRIME;
        m_rest.delete();
        m_hold.delete();
        m_cur = 1'b0;
    endfunction

    function automatic void model_load_bits(input logic [7:0] b);
        m_rest.delete();
        for (int k = 6; k >= 0; k--) m_rest.push_back(b[k]);
        m_cur = b[7];
    endfunction

    function automatic void model_step(input logic rst, input logic cs, input logic nc,
                                       input logic bv, input logic [7:0] bd);
        logic acc;
        acc = model_ready() && bv;
        if (rst) begin
            m_mode = M_IDLE; m_rest.delete(); m_hold.delete(); m_cur = 1'b0; m_p = 0;
            return;
        end
        case (m_mode)
            M_IDLE:  if (cs) model_prime();
            M_PRIME: if (acc) begin model_load_bits(bd); m_idx = 1; m_mode = M_SHIFT; end
            M_SHIFT: begin
                if (m_idx == TOTAL) begin
                    m_mode = M_RUN; m_p = 0; m_rest.delete(); m_hold.delete(); m_cur = 1'b0;
                end else begin
                    if (m_rest.size() > 0) m_cur = m_rest.pop_front();
                    else if (m_hold.size() > 0) model_load_bits(m_hold.pop_front());
                    else begin m_mode = M_ERR; m_cur = 1'b0; end
                    if (m_mode == M_SHIFT) begin
                        m_idx++;
                        if (acc) m_hold.push_back(bd);
                    end
                end
            end
            M_RUN: begin
                if (cs)      model_prime();
                else if (nc) begin m_mode = M_CLEAR; m_clr = CLRC; end
                else         m_p = (m_p + 1) % 256;
            end
            M_CLEAR: begin
                if (cs)               model_prime();
                else if (nc)          m_clr = CLRC;
                else if (m_clr == 1)  begin m_mode = M_RUN; m_p = 0; end
                else                  m_clr--;
            end
            M_ERR:   if (cs) model_prime();
            default: m_mode = M_IDLE;
        endcase
    endfunction

    // ---------------- compare process + bit capture ----------------
    logic cap[$];
    int   run_len = 0;
    int   max_run = 0;

    always @(negedge clk) begin
        logic [14:0] e_v, a_v;
        if (chk_en) begin
            e_v = model_outputs();
            a_v = {conf_en, bs_in, brain_reset, dBus, byte_ready, busy, cfg_done, cfg_err};
            checks++;
            if (a_v !== e_v) begin
                errors++;
                if (nprint < 20)
                    $display("FAIL model_cycle t=%0t actual=%b required=%b (conf_en,bs_in,brain_reset,dBus,byte_ready,busy,cfg_done,cfg_err)",
                             $time, a_v, e_v);
                nprint++;
            end
            model_step(nn_reset, cfg_start, nn_clear, byte_valid, byte_data);
            if (conf_en === 1'b1) begin
                cap.push_back(bs_in);
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    logic [7:0] load_bytes[NB];
    int         ld_result;   // 0 run, 1 error, 2 reset abort, 3 timeout
    logic       st_busy, st_ready;

    function automatic int bit_mismatches();
        int n;
        logic [7:0] b;
        n = 0;
        if (cap.size() != TOTAL) return -1;
        for (int i = 0; i < TOTAL; i++) begin
            b = load_bytes[i / 8];
            if (cap[i] !== b[7 - (i % 8)]) n++;
        end
        return n;
    endfunction

    task automatic do_load(input int pct, input int gap_at, input int gap_len,
                           input int poke_cyc, input int reset_bit);
        int   k, wl, cyc, bits;
        logic acc, want;
        for (int i = 0; i < NB; i++) load_bytes[i] = 8'($urandom);
        cap.delete();
        max_run = 0;
        k = 0; wl = gap_len; cyc = 0; bits = 0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        st_busy = busy;
        st_ready = byte_ready;
        ld_result = 3;
        while (cyc < 3000) begin
            want = (k < NB) && ($urandom_range(0, 99) < pct);
            if (k == gap_at && wl > 0) begin
                want = 1'b0;
                if (byte_ready) wl--;
            end
            byte_valid = want;
            byte_data  = (k < NB) ? load_bytes[k] : 8'h00;
            cfg_start  = (cyc == poke_cyc);
            @(posedge clk);
            acc = byte_valid && byte_ready;
            #1;
            if (acc) k++;
            if (conf_en) bits++;
            cyc++;
            if (reset_bit > 0 && bits == reset_bit) begin
                byte_valid = 1'b0; cfg_start = 1'b0; nn_reset = 1'b1;
                tick();
                nn_reset = 1'b0;
                ld_result = 2;
                break;
            end
            if (cfg_done) begin ld_result = 0; break; end
            if (cfg_err)  begin ld_result = 1; break; end
        end
        byte_valid = 1'b0;
        cfg_start  = 1'b0;
        if (ld_result == 3) check("load_timeout", 1, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d0, d7, dph, br, dz;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (2) tick();
        check("reset_byte_ready", byte_ready, 0);
        check("reset_brain_reset", brain_reset, 1);
        check("reset_conf_en", conf_en, 0);
        check("reset_dbus", dBus, 0);
        nn_reset = 1'b0;
        repeat (3) tick();

        // full back-to-back load
        do_load(100, -1, 0, -1, 0);
        check("start_busy", st_busy, 1);
        check("start_byte_ready", st_ready, 1);
        check("full_result", ld_result, 0);
        check("full_run_len", max_run, TOTAL);
        check("full_bits", bit_mismatches(), 0);
        check("full_cfg_done", cfg_done, 1);

        // 512 RUN cycles of decay bus
        d0 = 0; d7 = 0; dph = 0;
        repeat (512) begin
            if (dBus[0]) d0++;
            if (dBus[7]) d7++;
            if (dBus[7] && dBus != 8'hFF) dph++;
            tick();
        end
        check("dbus0_count", d0, 256);
        check("dbus7_count", d7, 2);
        check("dbus_phase", dph, 0);

        // clear pulse
        nn_clear = 1'b1;
        tick();
        nn_clear = 1'b0;
        br = 0; dz = 0;
        repeat (6) begin
            if (brain_reset) br++;
            if (brain_reset && dBus != 8'h00) dz++;
            tick();
        end
        check("clear_len", br, CLRC);
        check("clear_dbus", dz, 0);

        // underrun: byte index 10 withheld while the block is ready
        do_load(100, 10, 12, -1, 0);
        check("underrun_result", ld_result, 1);
        check("underrun_cfg_err", cfg_err, 1);
        check("underrun_conf_en", conf_en, 0);
        check("underrun_bits", cap.size(), 80);
        repeat (3) tick();
        do_load(100, -1, 0, -1, 0);
        check("recover_result", ld_result, 0);
        check("recover_cfg_err", cfg_err, 0);
        check("recover_bits", bit_mismatches(), 0);
        repeat (20) tick();

        // cfg_start with nn_clear in RUN
        cfg_start = 1'b1; nn_clear = 1'b1;
        tick();
        cfg_start = 1'b0; nn_clear = 1'b0;
        check("both_busy", busy, 1);
        check("both_cfg_done", cfg_done, 0);
        tick();

        // cfg_start while shifting is ignored
        do_load(100, -1, 0, 100, 0);
        check("poke_result", ld_result, 0);
        check("poke_run_len", max_run, TOTAL);
        check("poke_bits", bit_mismatches(), 0);

        // reset mid-load at bit 200
        do_load(100, -1, 0, -1, 200);
        check("abort_result", ld_result, 2);
        check("abort_conf_en", conf_en, 0);
        check("abort_brain_reset", brain_reset, 1);
        check("abort_byte_ready", byte_ready, 0);
        check("abort_busy", busy, 0);

        // randomized loads and clears
        repeat (5) begin
            do_load($urandom_range(88, 100), -1, 0, $urandom_range(0, 1) ? int'($urandom_range(5, 400)) : -1, 0);
            repeat ($urandom_range(20, 120)) begin
                nn_clear = ($urandom_range(0, 99) < 6);
                tick();
            end
            nn_clear = 1'b0;
        end
        repeat (5) tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_brain_sequencer
`default_nettype wire

// File: doc/brain_sequencer.md
# brain_sequencer

Controller for the 5x5 BRAIN neuron array. It streams a configuration bitstream from a byte-wide valid/ready source into the array's serial chain (`conf_en`/`bs_in`). It then sequences the array's reset and run phases and generates the 8-line decay clock bus `dBus`. It sits between the host-facing byte interface and the BRAIN instance, which it drives directly.

## Interface
- `N_NEURONS`, default 25: neurons in the chain.
- `BITS_PER_NEURON`, default 17: bits per neuron, in shift order wA3, wB3, wC3, tSel3, U5.
- `CLEAR_CYCLES`, default 2: cycles `brain_reset` is held for an `nn_clear` request.
- `clk`  in  1  sole clock; all logic on posedge.
- `nn_reset`  in  1  synchronous, active-high reset of this block.
- `cfg_start`  in  1  pulse: begin loading a new bitstream.
- `byte_data`  in  8  bitstream byte, MSB shifted first.
- `byte_valid`  in  1  `byte_data` is valid.
- `byte_ready`  out  1  block accepts a byte this cycle.
- `nn_clear`  in  1  pulse: re-initialise membrane voltages while running.
- `conf_en`  out  1  to array: shift-enable.
- `bs_in`  out  1  to array: serial config bit.
- `brain_reset`  out  1  to array: its `nn_reset`.
- `dBus`  out  8  to array: decay clock bus.
- `busy`  out  1  high in PRIME or SHIFT.
- `cfg_done`  out  1  high in RUN or CLEAR.
- `cfg_err`  out  1  sticky underrun flag; cleared by `cfg_start` or `nn_reset`.

## Operation
- `TOTAL_BITS` = `N_NEURONS` × `BITS_PER_NEURON` = 425, which is 54 bytes. The last 7 bits of byte 54 are discarded.
- States:
  - IDLE: `brain_reset`=1, `conf_en`=0. `cfg_start` → PRIME.
  - PRIME: `byte_ready`=1, `brain_reset`=1. First accepted byte → SHIFT.
  - SHIFT: one bit per cycle on `bs_in` with `conf_en`=1, `brain_reset`=0.
    - An 8-bit shift register is backed by a 1-byte holding register.
    - `byte_ready`=1 while the holding register is empty.
    - When the shift register empties and the holding register is full, it reloads in the same cycle with no bubble.
    - If the shift register empties before bit 425 and the holding register is empty → ERR (underrun).
  - After bit 425 → RUN. Residual shift and holding contents are dropped.
  - RUN: `conf_en`=0, `brain_reset`=0, `dBus` active. `nn_clear` → CLEAR.
  - CLEAR: `brain_reset`=1 for `CLEAR_CYCLES`, `dBus`=0, prescaler held at 0, then → RUN.
  - ERR: `cfg_err`=1, `conf_en`=0, `brain_reset`=1, `dBus`=0. `cfg_start` → PRIME.
- A `conf_en` low cycle mid-load would make the array integrate and corrupt the load. Underrun is therefore fatal, never a stall.
- Decay bus:
  - An 8-bit prescaler `p` is cleared on entry to RUN and increments each RUN cycle, wrapping at 255.
  - `dBus[i]` = 1 iff `p[i:0]` is all ones, so line i pulses one cycle every 2^(i+1) cycles.
  - `dBus`=0 outside RUN.
- Command priority:
  - `cfg_start` in PRIME/SHIFT is ignored.
  - `cfg_start` in IDLE/RUN/CLEAR/ERR → PRIME; the bit counter and `cfg_err` are cleared.
  - `cfg_start` together with `nn_clear` in RUN: `cfg_start` wins.
  - `nn_clear` outside RUN is ignored.
  - `nn_clear` during CLEAR restarts the `CLEAR_CYCLES` count.
- `byte_ready`=0 in IDLE, RUN, CLEAR and ERR.

## Timing
- Reset values: state IDLE, `conf_en`=0, `bs_in`=0, `brain_reset`=1, `dBus`=0, `byte_ready`=0, `busy`=0, `cfg_done`=0, `cfg_err`=0.
- All outputs are registered.
- `cfg_start` at cycle t → PRIME and `byte_ready`=1 at t+1.
- Byte accepted at t in PRIME → `conf_en`=1 with `bs_in`=bit7 at t+1, bit0 at t+8.
- Bit 425 is presented at cycle s → at s+1 `conf_en`=0, `cfg_done`=1, `p`=0.
  - The first `dBus[0]` pulse is at s+2.
- Underrun: the cycle where a bit was due → `conf_en`=0 and `cfg_err`=1.
- `nn_reset` mid-load aborts at the next edge: `conf_en`=0, `brain_reset`=1.
- `dBus` changes only on posedge, so it is stable at the array's negedge sample.

## Structure
- Package `brain_pkg`:
  - state enum (IDLE, PRIME, SHIFT, RUN, CLEAR, ERR);
  - `N_NEURONS`, `BITS_PER_NEURON`, `TOTAL_BITS`;
  - 9-bit bit-counter width.
- Sub-module `decay_prescaler`: counter, clear and enable, `dBus` decode.
- Top: FSM, byte skid (shift plus holding register), bit counter, clear counter.

## Test plan
- Full load, 54 bytes offered back-to-back:
  - 425 consecutive `conf_en`=1 cycles, no bubbles;
  - `bs_in` sequence equals the MSB-first bits;
  - RUN entered; `cfg_done`=1.
- Withhold byte 10 for 12 cycles:
  - ERR once bit 80 has shifted; `cfg_err`=1; `conf_en`=0;
  - a later `cfg_start` followed by a full load → RUN with `cfg_err`=0.
- RUN for 512 cycles: `dBus[0]` high 256 times, `dBus[7]` high 2 times (at `p`=255), all lines in phase.
- `nn_clear` in RUN: `brain_reset`=1 for exactly 2 cycles with `dBus`=0; the prescaler restarts at 0.
- `nn_reset` asserted at bit 200: next cycle `conf_en`=0, `brain_reset`=1, IDLE, `byte_ready`=0.
- `cfg_start` and `nn_clear` together in RUN → PRIME, no CLEAR pulse. `cfg_start` in SHIFT → no effect; the bit count continues.
